// File: rtl/coherence_ctrl.sv
// coherence_ctrl: two-core MSI snoop sequencer and RAM arbiter for I/D cache traffic.
// Optional dirty-data forwarding to the requester: define COHERENCE_C2C_FWD_EN.
module coherence_ctrl #(
  parameter int         CPUS   = 2,
  parameter logic [1:0] ACCESS = 2'b10
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  input  logic [CPUS-1:0]       cctrans,
  input  logic [CPUS-1:0]       ccwrite,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic [3:0]            state_dbg
);

`ifdef COHERENCE_C2C_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ARB, SNOOP, SNRESP, C2C1, C2C2, MEMRD1, MEMRD2, WBACK, IFETCH
  } state_e;

  state_e      state_q, state_d;
  logic        core_q, core_d;   // requester r (coherence), or owner of WBACK/IFETCH
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        fill_q, fill_d;
  logic        dptr_q, dptr_d;
  logic        iptr_q, iptr_d;

  logic r, s, acc;
  logic cc_sel, wb_sel, if_sel;

  // Both requesting: the pointer decides; otherwise the lone requester wins.
  function automatic logic pick(input logic [1:0] req, input logic ptr);
    return (&req) ? ptr : req[1];
  endfunction

  assign r         = core_q;
  assign s         = ~core_q;
  assign acc       = (ramstate == ACCESS);
  assign cc_sel    = pick(cctrans, dptr_q);
  assign wb_sel    = pick(dWEN, dptr_q);
  assign if_sel    = pick(iREN, iptr_q);
  assign state_dbg = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      core_q  <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      fill_q  <= 1'b0;
      dptr_q  <= 1'b0;
      iptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      dptr_q  <= dptr_d;
      iptr_q  <= iptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    core_d      = core_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    fill_d      = fill_q;
    dptr_d      = dptr_q;
    iptr_d      = iptr_q;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        if (|cctrans) begin
          state_d = ARB;
        end else if (|dWEN) begin
          core_d  = wb_sel;
          dptr_d  = ~dptr_q;
          state_d = WBACK;
        end else if (|iREN) begin
          core_d  = if_sel;
          iptr_d  = ~iptr_q;
          state_d = IFETCH;
        end
      end

      ARB: begin
        if (|cctrans) begin
          core_d  = cc_sel;
          addr_d  = daddr[cc_sel];
          wr_d    = ccwrite[cc_sel];
          fill_d  = dREN[cc_sel];
          dptr_d  = ~dptr_q;
          state_d = SNOOP;
        end else begin
          state_d = IDLE;
        end
      end

      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = addr_q;
        ccinv[s]       = wr_q;
        state_d        = SNRESP;
      end

      SNRESP: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = addr_q;
        ccinv[s]       = wr_q;
        if (cctrans[s]) begin
          ccinv[r] = 1'b1;
          if (ccwrite[s])  state_d = C2C1;
          else if (fill_q) state_d = MEMRD1;
          else             state_d = IDLE;
        end
      end

      // Dirty owner flushes its two words; the requester may take them on the fly.
      C2C1, C2C2: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = addr_q;
        ramWEN         = 1'b1;
        ramaddr        = daddr[s];
        ramstore       = dstore[s];
        if (acc) begin
          dwait[s] = 1'b0;
          if (FWD && fill_q) begin
            dwait[r] = 1'b0;
            dload[r] = dstore[s];
          end
          if (state_q == C2C1)      state_d = C2C2;
          else if (FWD || !fill_q)  state_d = IDLE;
          else                      state_d = MEMRD1;
        end
      end

      MEMRD1, MEMRD2: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r];
        if (acc) begin
          dwait[r] = 1'b0;
          dload[r] = ramload;
          state_d  = (state_q == MEMRD1) ? MEMRD2 : IDLE;
        end
      end

      WBACK: begin
        if (dWEN[r]) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[r];
          ramstore = dstore[r];
          if (acc) dwait[r] = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r];
        if (acc) begin
          iwait[r] = 1'b0;
          iload[r] = ramload;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
